// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// status bit positions, FSM encoding and the divisor clamp.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int BUSY  = 0;
  localparam int FULL  = 1;
  localparam int EMPTY = 2;
  localparam int OVF   = 3;

  localparam logic [15:0] DEFAULT_DIV = 16'd434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // A divisor below 2 cannot form a bit period, so it is clamped.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/uart_tx_io_16_if.sv
// CPU bus seen by the UART: address, write data, write strobe and read data.
interface uart_tx_io_16_if;
  logic [15:0] addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        we;

  modport master (output addr, output din, output we, input dout);
  modport slave  (input addr, input din, input we, output dout);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output; pushes into a full
// FIFO and pops from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  // Pointers wrap naturally; count carries the extra bit to tell full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_io_16.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a TX FIFO and
// the FSM serialises them on txd at a programmable baud divisor.
module uart_tx_io_16 #(
  parameter logic [15:0] BASE_ADDR   = 16'h5000,
  parameter logic [15:0] DEFAULT_DIV = uart_pkg::DEFAULT_DIV,
  parameter int          FIFO_AW     = 3
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_io_16_if.slave  bus,
  output logic            txd
);

  import uart_pkg::*;

  logic               hit;
  logic [1:0]         offset;
  logic               wr_txdata;
  logic               wr_status;
  logic               wr_div;
  logic               fifo_pop;
  logic [7:0]         fifo_dout;
  logic [FIFO_AW:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [15:0]        div_reg;
  logic               ovf;
  logic               busy;
  logic [7:0]         status;

  tx_state_e          state;
  logic [7:0]         shift;
  logic [15:0]        baud_cnt;
  logic [15:0]        bit_div;
  logic [2:0]         bit_idx;
  logic               bit_end;

  assign hit       = (bus.addr[15:2] == BASE_ADDR[15:2]);
  assign offset    = bus.addr[1:0];
  assign wr_txdata = bus.we && hit && (offset == REG_TXDATA);
  assign wr_status = bus.we && hit && (offset == REG_STATUS);
  assign wr_div    = bus.we && hit && (offset == REG_DIV);

  assign busy     = (state != IDLE);
  assign bit_end  = (baud_cnt == bit_div - 16'd1);
  assign fifo_pop = !fifo_empty && ((state == IDLE) || (state == STOP && bit_end));

  sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_txdata),
    .pop      (fifo_pop),
    .data_in  (bus.din[7:0]),
    .data_out (fifo_dout),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Overflow is judged on the pre-edge full flag, matching the FIFO's drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg <= DEFAULT_DIV;
      ovf     <= 1'b0;
    end else begin
      if (wr_div) div_reg <= bus.din;
      if (wr_txdata && fifo_full) ovf <= 1'b1;
      else if (wr_status && bus.din[OVF]) ovf <= 1'b0;
    end
  end

  // The divisor is captured at frame start so DIV writes only affect later frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shift    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      bit_div  <= eff_div(DEFAULT_DIV);
      txd      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shift    <= fifo_dout;
            baud_cnt <= '0;
            bit_idx  <= '0;
            bit_div  <= eff_div(div_reg);
            txd      <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            txd      <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (!fifo_empty) begin
              shift   <= fifo_dout;
              bit_idx <= '0;
              bit_div <= eff_div(div_reg);
              txd     <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    status        = '0;
    status[7:4]   = 4'(fifo_count);
    status[OVF]   = ovf;
    status[EMPTY] = fifo_empty;
    status[FULL]  = fifo_full;
    status[BUSY]  = busy;
  end

  always_comb begin
    bus.dout = '0;
    if (hit) begin
      case (offset)
        REG_STATUS: bus.dout = {8'h00, status};
        REG_DIV:    bus.dout = div_reg;
        default:    bus.dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_io_16.sv
// Bench for uart_tx_io_16: directed scenarios plus random bus traffic checked
// against a queue-based model of the FIFO and the expected txd waveform.
module tb_uart_tx_io_16;

  localparam logic [15:0] A_TX  = 16'h5000;
  localparam logic [15:0] A_ST  = 16'h5001;
  localparam logic [15:0] A_DIV = 16'h5002;
  localparam logic [15:0] A_RSV = 16'h5003;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic txd;

  uart_tx_io_16_if bus();

  uart_tx_io_16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: pending bytes, and the txd level expected for each upcoming cycle.
  logic [7:0]  m_q[$];
  logic        m_line[$];
  logic        m_ovf;
  logic [15:0] m_div;
  int          m_pre;
  int          m_d;
  logic [7:0]  m_b;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // A frame is start(0), data LSB first, stop(1), each held for max(div,2) cycles;
  // a new frame starts on the edge the line runs out if a byte is waiting.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_line.delete();
      m_ovf = 1'b0;
      m_div = 16'd434;
    end else begin
      m_pre = m_q.size();
      if (m_line.size() != 0) void'(m_line.pop_front());
      if (m_line.size() == 0 && m_pre > 0) begin
        m_b = m_q.pop_front();
        m_d = (m_div < 16'd2) ? 2 : int'(m_div);
        for (int k = 0; k < 10; k++)
          for (int r = 0; r < m_d; r++)
            m_line.push_back((k == 0) ? 1'b0 : ((k == 9) ? 1'b1 : m_b[k-1]));
      end
      if (bus.we) begin
        if (bus.addr == A_TX) begin
          if (m_pre == 8) m_ovf = 1'b1;
          else m_q.push_back(bus.din[7:0]);
        end else if (bus.addr == A_ST) begin
          if (bus.din[3]) m_ovf = 1'b0;
        end else if (bus.addr == A_DIV) begin
          m_div = bus.din;
        end
      end
    end
  end

  function automatic logic [15:0] model_read(input logic [15:0] a);
    logic [3:0] cnt;
    cnt = 4'(m_q.size());
    if (a == A_ST)
      return {8'h00, cnt, m_ovf, (m_q.size() == 0), (m_q.size() == 8), (m_line.size() != 0)};
    if (a == A_DIV) return m_div;
    return 16'h0000;
  endfunction

  always @(negedge clk) begin
    if (!reset)
      checkOutput("txd_model", {15'b0, txd}, {15'b0, (m_line.size() != 0) ? m_line[0] : 1'b1});
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d, input logic w);
    bus.addr = a;
    bus.din  = d;
    bus.we   = w;
    @(negedge clk);
    bus.we   = 1'b0;
    bus.addr = 16'h0000;
  endtask

  task automatic readExpect(input string tag, input logic [15:0] a, input logic [15:0] exp);
    bus.addr = a;
    bus.we   = 1'b0;
    #1;
    checkOutput(tag, bus.dout, exp);
    @(negedge clk);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0]  frame;
    logic [15:0] div_choices [5];
    logic [15:0] ra;
    int          sel;
    int          guard;

    div_choices = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5};
    bus.addr = 16'h0000;
    bus.din  = 16'h0000;
    bus.we   = 1'b0;
    waitCycles(2);
    reset = 1'b0;

    $display("[TB] reset values");
    readExpect("rst_status", A_ST, 16'h0004);
    readExpect("rst_div", A_DIV, 16'd434);
    checkOutput("rst_txd", {15'b0, txd}, 16'h0001);
    readExpect("out_of_window", 16'h5004, 16'h0000);
    readExpect("reserved", A_RSV, 16'h0000);
    readExpect("txdata_read", A_TX, 16'h0000);

    $display("[TB] single frame 0xA5 at div 4");
    applyStimulus(A_DIV, 16'd4, 1'b1);
    applyStimulus(A_TX, 16'h00A5, 1'b1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checkOutput("a5_bit", {15'b0, txd}, {15'b0, frame[k/4]});
    end
    readExpect("a5_busy_40", A_ST, 16'h0005);
    readExpect("a5_idle_41", A_ST, 16'h0004);

    $display("[TB] back-to-back frames");
    applyStimulus(A_TX, 16'h0001, 1'b1);
    applyStimulus(A_TX, 16'h0080, 1'b1);
    waitCycles(79);
    readExpect("b2b_busy_80", A_ST, 16'h0005);
    readExpect("b2b_idle_81", A_ST, 16'h0004);

    $display("[TB] fifo full and overflow");
    applyStimulus(A_DIV, 16'd1000, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(A_TX, 16'(i + 16'h10), 1'b1);
    readExpect("full_status", A_ST, 16'h0083);
    applyStimulus(A_TX, 16'h0099, 1'b1);
    readExpect("ovf_status", A_ST, 16'h008B);
    applyStimulus(A_ST, 16'h0008, 1'b1);
    readExpect("ovf_clear", A_ST, 16'h0083);
    doReset();
    readExpect("flush_status", A_ST, 16'h0004);

    $display("[TB] divisor change mid-frame");
    applyStimulus(A_DIV, 16'd4, 1'b1);
    applyStimulus(A_TX, 16'h003C, 1'b1);
    waitCycles(10);
    applyStimulus(A_DIV, 16'd8, 1'b1);
    applyStimulus(A_TX, 16'h00C3, 1'b1);
    readExpect("div8_read", A_DIV, 16'd8);
    waitCycles(150);
    applyStimulus(A_DIV, 16'd0, 1'b1);
    readExpect("div0_read", A_DIV, 16'd0);
    applyStimulus(A_TX, 16'h005A, 1'b1);
    frame = {1'b1, 8'h5A, 1'b0};
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("div0_bit", {15'b0, txd}, {15'b0, frame[k/2]});
    end
    waitCycles(2);

    $display("[TB] async reset mid-frame");
    applyStimulus(A_DIV, 16'd4, 1'b1);
    applyStimulus(A_TX, 16'h0000, 1'b1);
    applyStimulus(A_TX, 16'h0011, 1'b1);
    applyStimulus(A_TX, 16'h0022, 1'b1);
    applyStimulus(A_TX, 16'h0033, 1'b1);
    waitCycles(15);
    checkOutput("pre_rst_txd", {15'b0, txd}, 16'h0000);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_txd", {15'b0, txd}, 16'h0001);
    @(negedge clk);
    reset = 1'b0;
    readExpect("post_rst_status", A_ST, 16'h0004);
    waitCycles(60);
    checkOutput("no_frames_txd", {15'b0, txd}, 16'h0001);
    readExpect("still_empty", A_ST, 16'h0004);

    $display("[TB] random traffic");
    applyStimulus(A_DIV, 16'd3, 1'b1);
    for (int it = 0; it < 800; it++) begin
      sel = $urandom_range(0, 99);
      if (sel < 35) begin
        applyStimulus(A_TX, 16'($urandom_range(0, 255)), 1'b1);
      end else if (sel < 40) begin
        applyStimulus(A_DIV, div_choices[$urandom_range(0, 4)], 1'b1);
      end else if (sel < 45) begin
        applyStimulus(A_ST, 16'($urandom), 1'b1);
      end else if (sel < 48) begin
        applyStimulus(16'h6000 | 16'($urandom_range(0, 3)), 16'($urandom), 1'b1);
      end else if (sel < 88) begin
        case ($urandom_range(0, 5))
          0: ra = A_TX;
          1: ra = A_ST;
          2: ra = A_DIV;
          3: ra = A_RSV;
          4: ra = 16'h5004;
          default: ra = 16'($urandom);
        endcase
        readExpect("rand_read", ra, model_read(ra));
      end else begin
        waitCycles($urandom_range(1, 30));
      end
    end

    guard = 0;
    while ((m_q.size() != 0 || m_line.size() != 0) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain_done", {15'b0, (guard < 5000)}, 16'h0001);
    readExpect("final_status", A_ST, model_read(A_ST));
    checkOutput("final_txd", {15'b0, txd}, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
